branch_predict_table: RTL and testbench
=======================================

# branch_predict_table

Parametrised branch history/target table for the fetch stage. It predicts the direction and target of the instruction at the fetch PC, and is trained by the resolved branch decision and target computed in instruction decode. Each entry holds a valid bit, tag, target, jump flag and saturating counter. Comparing decode's resolution with the prediction that travelled down the pipe produces a registered mispredict/redirect for the fetch unit.

## Interface
- ENTRIES, 64: table depth; power of two, at least 4; IDX_W = $clog2(ENTRIES).
- TAG_W, 8: tag width; IDX_W+TAG_W+2 must be at most 32.
- CTR_W, 2: saturating counter width, at least 2.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  32  PC being fetched.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  32  predicted next PC.
- upd_valid  in  1  one-cycle pulse: decode resolved a branch/jump.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved decision.
- upd_target  in  32  resolved target.
- upd_is_jump  in  1  JAL/JALR.
- upd_pred_taken  in  1  prediction made at fetch for this instruction.
- upd_pred_target  in  32  predicted target made at fetch.
- mispredict  out  1  registered one-cycle flush request.
- redirect_pc  out  32  correct next PC, valid while mispredict is high.
- ready  out  1  table initialised; lookups and updates are live.
- stat_updates  out  32  count of accepted updates (see Configuration).
- stat_mispredicts  out  32  count of mispredicts (see Configuration).

## Operation
- Index is pc[IDX_W+1:2]; tag is pc[IDX_W+TAG_W+1:IDX_W+2].
- States:
  - INIT: entered while reset is high. init_idx = 0.
  - INIT, each edge with reset low: writes entry init_idx with valid=0 and counter = weakly-not-taken (01 followed by zeros), then increments init_idx.
  - INIT to RUN: after the write of init_idx = ENTRIES-1.
  - RUN: holds until reset.
- Lookup (combinational):
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && (jump flag || counter MSB).
  - pred_target = stored target if pred_taken, else fetch_pc+4 (modulo 2^32).
  - When ready=0: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4.
- Update, only in RUN with upd_valid=1; updates are ignored when ready=0:
  - Taken and hit: counter saturating-increments; target, jump flag and tag are rewritten.
  - Taken and miss: allocate or overwrite with valid=1, tag, target, jump flag, and counter = weakly-taken (10 followed by zeros).
  - Jump: counter is forced to all-ones.
  - Not taken and hit: counter saturating-decrements; the entry stays valid.
  - Not taken and miss: no change.
- Mispredict:
  - m = upd_valid && ready && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Arithmetic: all PC math is 32-bit unsigned and wraps. Counters never wrap.

## Timing
- Lookup: zero latency, combinational from current table contents.
- Update: written at the next rising edge. A lookup to the same index in the same cycle returns the old contents.
- Mispredict/redirect_pc: registered, high exactly the cycle after the update. Back-to-back updates produce back-to-back results.
- Reset values: ready=0, mispredict=0, redirect_pc=0, stats=0, state=INIT.
- ready rises after exactly ENTRIES rising edges with reset low.
- Reset asserted mid-INIT or in RUN: next edge returns to INIT with init_idx=0, ready=0 and mispredict=0. Any in-flight mispredict is dropped.
- Update on the last INIT cycle: ignored.

## Configuration
- BPT_STATS_EN defined:
  - stat_updates increments on each accepted update.
  - stat_mispredicts increments on each mispredict.
  - Both saturate at 0xFFFF_FFFF and clear on reset.
- BPT_STATS_EN undefined: the ports remain and are tied to 0, and no counter logic is built.

## Test plan
All scenarios use ENTRIES=16 and TAG_W=8.
- Reset, then release: ready=0 for 16 edges, then ready=1. Lookup of 0x40 gives pred_hit=0, pred_target=0x44.
- Update pc=0x40, taken, target=0x100, pred_taken=0: next cycle mispredict=1 and redirect_pc=0x100. Lookup of 0x40 then gives hit, taken, 0x100.
- Same entry, two not-taken updates: counter goes 10 to 01 to 00. Lookup gives hit=1, taken=0, target=0x44. A third not-taken update keeps the counter at 00.
- Alias: update pc=0x440 (same index, tag 0x11) as taken. Lookup 0x40 then misses and lookup 0x440 hits. A JAL update gives taken with counter 11.
- Update with reset asserted the same cycle: mispredict stays 0, state is INIT, and ready is 0 for 16 edges.
- BPT_STATS_EN defined: 5 updates including 2 mispredicts give stat_updates=5 and stat_mispredicts=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/branch_predict_table_if.sv
// Fetch lookup, decode update and mispredict/statistics signals of branch_predict_table.
// master: fetch/decode side, slave: the table.
interface branch_predict_table_if;
  logic [31:0] fetch_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_is_jump;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        ready;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc, ready,
           stat_updates, stat_mispredicts
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc, ready,
           stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_table.sv
// Direct-mapped branch history/target table with registered mispredict/redirect.
// Define BPT_STATS_EN to build the saturating update/mispredict counters.
module branch_predict_table #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2
) (
  input logic                   clk,
  input logic                   reset,
  branch_predict_table_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(1) << (CTR_W - 2);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             jump;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  entry_t           table_q [ENTRIES];

  logic             ready;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == S_INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  assign ready = (state_q == S_RUN);

  // Lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  entry_t           f_ent;
  logic             f_hit, f_taken;

  always_comb begin
    f_idx   = bus.fetch_pc[IDX_W+1:2];
    f_tag   = bus.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    f_ent   = table_q[f_idx];
    f_hit   = ready && f_ent.valid && (f_ent.tag == f_tag);
    f_taken = f_hit && (f_ent.jump || f_ent.ctr[CTR_W-1]);
  end

  assign bus.pred_hit    = f_hit;
  assign bus.pred_taken  = f_taken;
  assign bus.pred_target = f_taken ? f_ent.target : bus.fetch_pc + 32'd4;

  // Update / initialisation write port
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  entry_t           u_ent;
  logic             u_hit, upd_accept;
  logic             we;
  logic [IDX_W-1:0] w_idx;
  entry_t           w_ent;

  always_comb begin
    u_idx      = bus.upd_pc[IDX_W+1:2];
    u_tag      = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    u_ent      = table_q[u_idx];
    u_hit      = u_ent.valid && (u_ent.tag == u_tag);
    upd_accept = ready && bus.upd_valid;

    we    = 1'b0;
    w_idx = u_idx;
    w_ent = u_ent;
    if (state_q == S_INIT) begin
      we        = 1'b1;
      w_idx     = init_idx_q;
      w_ent     = '0;
      w_ent.ctr = CTR_WNT;
    end else if (upd_accept) begin
      if (bus.upd_taken) begin
        we           = 1'b1;
        w_ent.valid  = 1'b1;
        w_ent.tag    = u_tag;
        w_ent.target = bus.upd_target;
        w_ent.jump   = bus.upd_is_jump;
        if (bus.upd_is_jump)  w_ent.ctr = CTR_MAX;
        else if (!u_hit)      w_ent.ctr = CTR_WT;
        else if (u_ent.ctr != CTR_MAX) w_ent.ctr = u_ent.ctr + 1'b1;
      end else if (u_hit) begin
        we = 1'b1;
        if (u_ent.ctr != '0) w_ent.ctr = u_ent.ctr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we) table_q[w_idx] <= w_ent;
  end

  // Mispredict detection
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_q, redirect_d;

  always_comb begin
    mispredict_d = upd_accept &&
                   ((bus.upd_taken != bus.upd_pred_taken) ||
                    (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    redirect_d   = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      if (mispredict_d) redirect_q <= redirect_d;
    end
  end

  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.ready       = ready;

`ifdef BPT_STATS_EN
  logic [31:0] stat_upd_q, stat_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (upd_accept && (stat_upd_q != '1))   stat_upd_q <= stat_upd_q + 1'b1;
      if (mispredict_d && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 1'b1;
    end
  end

  assign bus.stat_updates     = stat_upd_q;
  assign bus.stat_mispredicts = stat_mis_q;
`else
  assign bus.stat_updates     = '0;
  assign bus.stat_mispredicts = '0;
`endif

  // PC bits outside index/tag are intentionally ignored
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc, bus.upd_pc};

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed self-checking bench for branch_predict_table (ENTRIES=16, TAG_W=8).
module tb_branch_predict_table;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_predict_table_if bus ();

  branch_predict_table #(.ENTRIES(16), .TAG_W(8), .CTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
    bus.fetch_pc = pc;
    #1;
    chk({tag, ".hit"},    32'(bus.pred_hit),   32'(hit));
    chk({tag, ".taken"},  32'(bus.pred_taken), 32'(taken));
    chk({tag, ".target"}, bus.pred_target,     tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic jump, input logic ptaken, input logic [31:0] ptgt);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = taken;
    bus.upd_target      = tgt;
    bus.upd_is_jump     = jump;
    bus.upd_pred_taken  = ptaken;
    bus.upd_pred_target = ptgt;
  endtask

  // Drive one update, return #1 after the edge that consumed it
  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic jump, input logic ptaken, input logic [31:0] ptgt);
    set_upd(pc, taken, tgt, jump, ptaken, ptgt);
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic chk_mis(input string tag, input logic m, input logic [31:0] rpc);
    chk({tag, ".mispredict"}, 32'(bus.mispredict), 32'(m));
    if (m) chk({tag, ".redirect"}, bus.redirect_pc, rpc);
  endtask

  initial begin
    bus.fetch_pc = 32'h40;
    set_upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.upd_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready",      32'(bus.ready),       32'd0);
    chk("rst.mispredict", 32'(bus.mispredict),  32'd0);
    chk("rst.redirect",   bus.redirect_pc,      32'd0);
    chk("rst.stat_upd",   bus.stat_updates,     32'd0);
    chk("rst.stat_mis",   bus.stat_mispredicts, 32'd0);
    lookup("rst.lk40", 32'h40, 1'b0, 1'b0, 32'h44);

    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("init.ready%0d", i), 32'(bus.ready), 32'(i == 16));
    end
    lookup("run.lk40", 32'h40, 1'b0, 1'b0, 32'h44);
    lookup("run.wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Allocate on taken miss
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
    chk_mis("alloc", 1'b1, 32'h100);
    lookup("alloc.lk", 32'h40, 1'b1, 1'b1, 32'h100);
    @(posedge clk); #1;
    chk("alloc.mis_drop", 32'(bus.mispredict), 32'd0);

    // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
    upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk_mis("nt1", 1'b1, 32'h44);
    lookup("nt1.lk", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44);
    chk_mis("nt2", 1'b0, 32'h0);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44);
    lookup("nt3.lk", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
    lookup("sat0.lk", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
    lookup("up10.lk", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100);
    chk_mis("tt_ok", 1'b0, 32'h0);
    upd(32'h40, 1'b1, 32'h120, 1'b0, 1'b1, 32'h100);
    chk_mis("tgt_mis", 1'b1, 32'h120);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h120);
    lookup("sat3.lk", 32'h40, 1'b1, 1'b1, 32'h120);

    // Redirect wraps past 2^32; not-taken miss leaves table alone
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8);
    chk_mis("wrap", 1'b1, 32'h0);
    lookup("wrap.lk", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Alias: same index, tag 0x11
    upd(32'h440, 1'b1, 32'h200, 1'b0, 1'b0, 32'h444);
    lookup("alias.old", 32'h40, 1'b0, 1'b0, 32'h44);
    lookup("alias.new", 32'h440, 1'b1, 1'b1, 32'h200);
    upd(32'h440, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    upd(32'h440, 1'b0, 32'h0, 1'b0, 1'b0, 32'h444);
    lookup("alias.ctr00", 32'h440, 1'b1, 1'b0, 32'h444);
    upd(32'h440, 1'b1, 32'h300, 1'b1, 1'b0, 32'h444);
    lookup("jal.lk", 32'h440, 1'b1, 1'b1, 32'h300);
    upd(32'h440, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300);
    upd(32'h440, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    lookup("jal.ctr11", 32'h440, 1'b1, 1'b1, 32'h300);

    // Reset wins over a same-cycle update
    set_upd(32'h440, 1'b1, 32'h500, 1'b0, 1'b0, 32'h444);
    reset = 1'b1;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    reset = 1'b0;
    chk("rst2.mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst2.ready",      32'(bus.ready),      32'd0);
    chk("rst2.stat_upd",   bus.stat_updates,    32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reinit.ready%0d", i), 32'(bus.ready), 32'(i == 16));
      if (i == 15) set_upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
      if (i == 16) begin
        bus.upd_valid = 1'b0;
        chk("lastinit.mispredict", 32'(bus.mispredict), 32'd0);
      end
    end
    lookup("reinit.lk40",  32'h40,  1'b0, 1'b0, 32'h44);
    lookup("reinit.lk440", 32'h440, 1'b0, 1'b0, 32'h444);

    // Statistics: 5 accepted updates, 2 mispredicts
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100);
    upd(32'h80, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84);
    upd(32'h40, 1'b1, 32'h180, 1'b0, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0,   1'b0, 1'b0, 32'h44);
`ifdef BPT_STATS_EN
    chk("stat.updates",     bus.stat_updates,     32'd5);
    chk("stat.mispredicts", bus.stat_mispredicts, 32'd2);
`else
    chk("stat.updates",     bus.stat_updates,     32'd0);
    chk("stat.mispredicts", bus.stat_mispredicts, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
